// File: rtl/whack_mole_game.sv
// Whack-a-mole game controller: pops one mole at a time in a pseudo-random hole, scores hits, ends after ROUNDS moles.
// Latency: all outputs registered; a hit or timeout shows up on map/score on the edge after the hit cycle.
// Backpressure: none; start/hit are single-cycle pulses, and any pulse not accepted in the current state is dropped.
module whack_mole_game #(
  parameter logic [31:0] GAP_TICKS  = 32'd25_000_000,
  parameter logic [31:0] MOLE_TICKS = 32'd50_000_000,
  parameter logic [3:0]  ROUNDS     = 4'd15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] hit,
  output logic [8:0] map,
  output logic [3:0] score,
  output logic       playing,
  output logic       game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The timer only ever needs to reach the larger of the two phase lengths minus one.
  localparam logic [31:0] T_MAX = (GAP_TICKS > MOLE_TICKS) ? GAP_TICKS : MOLE_TICKS;
  localparam int          TW    = (T_MAX > 32'd1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 32'd1);
  localparam logic [TW-1:0] MOLE_LAST = TW'(MOLE_TICKS - 32'd1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_round;
  logic [3:0]    r_prev_hole;
  logic [7:0]    r_lfsr;
  logic [8:0]    r_map;
  logic [3:0]    r_score;
  logic          r_playing;
  logic          r_game_over;

  logic       w_fb;
  logic [3:0] w_mod;
  logic [3:0] w_idx;
  logic       w_hit_ok;
  logic       w_timeout;
  logic       w_last_round;

  // x^8+x^6+x^5+x^4+1 is primitive, so a nonzero seed never collapses to zero.
  assign w_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_mod = 4'(r_lfsr % 8'd9);
  // Bump to the next hole when the draw repeats the last one, so consecutive moles always move.
  assign w_idx = (w_mod != r_prev_hole) ? w_mod :
                 (w_mod == 4'd8)        ? 4'd0  : (w_mod + 4'd1);

  // Any matching bit counts; stray bits for other holes are simply ignored.
  assign w_hit_ok     = |(hit & r_map);
  assign w_timeout    = (r_timer == MOLE_LAST);
  assign w_last_round = ((r_round + 4'd1) == ROUNDS);

  // Free-running hole generator, advances every cycle outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  // Game FSM; playing/game_over are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_round     <= '0;
      r_prev_hole <= '0;
      r_map       <= '0;
      r_score     <= '0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_score     <= '0;
            r_round     <= '0;
            r_timer     <= '0;
            r_state     <= S_GAP;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_timer == GAP_LAST) begin
            r_map       <= 9'b1 << w_idx;
            r_prev_hole <= w_idx;
            r_timer     <= '0;
            r_state     <= S_UP;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        S_UP: begin
          // A hit on the final visible cycle wins over the timeout.
          if (w_hit_ok || w_timeout) begin
            r_map   <= '0;
            r_round <= r_round + 4'd1;
            if (w_hit_ok) begin
              r_score <= r_score + 4'd1;
            end
            if (w_last_round) begin
              r_state     <= S_DONE;
              r_playing   <= 1'b0;
              r_game_over <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_timer <= '0;
            end
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign map       = r_map;
  assign score     = r_score;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_whack_mole_game.sv
// Self-checking bench for whack_mole_game with short timing parameters.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: none; expected scores queue up as hits are driven and are popped at the following sample.
module tb_whack_mole_game;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [8:0] hit = '0;
  logic [8:0] map;
  logic [3:0] score;
  logic       playing;
  logic       game_over;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  whack_mole_game #(
    .GAP_TICKS (32'd4),
    .MOLE_TICKS(32'd8),
    .ROUNDS    (4'd3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .hit      (hit),
    .map      (map),
    .score    (score),
    .playing  (playing),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the game reports done, bounded; callers check game_over afterwards.
  task automatic wait_done();
    for (int i = 0; i < 200 && game_over !== 1'b1; i++) tick();
  endtask

  // Advance until a mole is visible, bounded; callers check map afterwards.
  task automatic wait_mole();
    for (int i = 0; i < 20 && map === 9'd0; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; hit = '0;
    repeat (3) tick();
    n_vec++;
    if ({map, score, playing, game_over} !== 15'd0) begin
      n_miss++;
      $display("FAIL reset_outputs: map=%b score=%0d playing=%b game_over=%b, want all 0", map, score, playing, game_over);
    end
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_vec++;
      if ({map, score, playing, game_over} !== 15'd0) begin
        n_miss++;
        $display("FAIL idle_hold cyc %0d: map=%b score=%0d playing=%b game_over=%b, want all 0", i, map, score, playing, game_over);
      end
    end
  endtask

  task automatic test_no_hits();
    logic [8:0] mole;
    logic [8:0] prev;
    prev = '0;
    start = 1'b1; exp_q.push_back(4'd0);
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (score !== e) begin
      n_miss++;
      $display("FAIL nohit_start_score: got %0d want %0d", score, e);
    end
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 4; k++) begin
        n_vec++;
        if (map !== 9'd0 || playing !== 1'b1) begin
          n_miss++;
          $display("FAIL nohit_gap m%0d k%0d: map=%b playing=%b, want map=0 playing=1", m, k, map, playing);
        end
        tick();
      end
      mole = map;
      n_vec++;
      if (!$onehot(mole)) begin
        n_miss++;
        $display("FAIL nohit_onehot m%0d: map=%b, want one-hot", m, mole);
      end
      if (m > 0) begin
        n_vec++;
        if (mole === prev) begin
          n_miss++;
          $display("FAIL nohit_distinct m%0d: map=%b same as previous %b", m, mole, prev);
        end
      end
      prev = mole;
      for (int k = 0; k < 8; k++) begin
        n_vec++;
        if (map !== mole || score !== 4'd0) begin
          n_miss++;
          $display("FAIL nohit_up m%0d k%0d: map=%b score=%0d, want map=%b score=0", m, k, map, score, mole);
        end
        tick();
      end
    end
    n_vec++;
    if (map !== 9'd0 || score !== 4'd0 || game_over !== 1'b1 || playing !== 1'b0) begin
      n_miss++;
      $display("FAIL nohit_end: map=%b score=%0d game_over=%b playing=%b, want 0/0/1/0", map, score, game_over, playing);
    end
  endtask

  task automatic test_hit_third();
    logic [8:0] mole;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mole = map;
    n_vec++;
    if (!$onehot(mole)) begin
      n_miss++;
      $display("FAIL hit3_onehot: map=%b, want one-hot", mole);
    end
    repeat (2) tick();
    hit = mole; exp_q.push_back(4'd1);
    tick();
    hit = '0;
    e = exp_q.pop_front();
    n_vec++;
    if (score !== e || map !== 9'd0) begin
      n_miss++;
      $display("FAIL hit3_score: score=%0d map=%b, want score=%0d map=0", score, map, e);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (map !== 9'd0) begin
        n_miss++;
        $display("FAIL hit3_gap k%0d: map=%b, want 0", k, map);
      end
      tick();
    end
    n_vec++;
    if (!$onehot(map) || map === mole) begin
      n_miss++;
      $display("FAIL hit3_next_mole: map=%b, want one-hot and not %b", map, mole);
    end
    wait_done();
    n_vec++;
    if (game_over !== 1'b1 || score !== 4'd1) begin
      n_miss++;
      $display("FAIL hit3_final: game_over=%b score=%0d, want 1/1", game_over, score);
    end
  endtask

  task automatic test_wrong_hole();
    logic [8:0] mole;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    mole = map;
    hit = {mole[7:0], mole[8]}; exp_q.push_back(4'd0);
    tick();
    hit = '0;
    e = exp_q.pop_front();
    n_vec++;
    if (score !== e || map !== mole) begin
      n_miss++;
      $display("FAIL wrong_hole: score=%0d map=%b, want score=%0d map=%b", score, map, e, mole);
    end
    repeat (6) tick();
    n_vec++;
    if (map !== mole) begin
      n_miss++;
      $display("FAIL wrong_still_up_8th: map=%b, want %b", map, mole);
    end
    hit = mole; exp_q.push_back(4'd1);
    tick();
    hit = '0;
    e = exp_q.pop_front();
    n_vec++;
    if (score !== e || map !== 9'd0) begin
      n_miss++;
      $display("FAIL hit_on_timeout: score=%0d map=%b, want score=%0d map=0", score, map, e);
    end
    wait_done();
    n_vec++;
    if (game_over !== 1'b1 || score !== 4'd1) begin
      n_miss++;
      $display("FAIL wrong_final: game_over=%b score=%0d, want 1/1", game_over, score);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; exp_q.push_back(4'd0);
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (score !== e || playing !== 1'b1 || game_over !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_start: score=%0d playing=%b game_over=%b, want %0d/1/0", score, playing, game_over, e);
    end
    for (int m = 0; m < 3; m++) begin
      wait_mole();
      n_vec++;
      if (!$onehot(map)) begin
        n_miss++;
        $display("FAIL b2b_mole m%0d: map=%b, want one-hot", m, map);
      end
      hit = map; exp_q.push_back(4'(m + 1));
      tick();
      hit = '0;
      e = exp_q.pop_front();
      n_vec++;
      if (score !== e || map !== 9'd0) begin
        n_miss++;
        $display("FAIL b2b_hit m%0d: score=%0d map=%b, want score=%0d map=0", m, score, map, e);
      end
      if (m == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        n_vec++;
        if (score !== 4'd1 || playing !== 1'b1 || game_over !== 1'b0) begin
          n_miss++;
          $display("FAIL midgame_start: score=%0d playing=%b game_over=%b, want 1/1/0", score, playing, game_over);
        end
      end
    end
    n_vec++;
    if (score !== 4'd3 || game_over !== 1'b1 || playing !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_final: score=%0d game_over=%b playing=%b, want 3/1/0", score, game_over, playing);
    end
    start = 1'b1; exp_q.push_back(4'd0);
    tick();
    start = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (score !== e || playing !== 1'b1 || game_over !== 1'b0) begin
      n_miss++;
      $display("FAIL restart: score=%0d playing=%b game_over=%b, want %0d/1/0", score, playing, game_over, e);
    end
  endtask

  task automatic test_reset_mid();
    wait_mole();
    hit = map;
    tick();
    hit = '0;
    wait_mole();
    n_vec++;
    if (map === 9'd0 || score !== 4'd1) begin
      n_miss++;
      $display("FAIL rstmid_setup: map=%b score=%0d, want mole up and score=1", map, score);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if ({map, score, playing, game_over} !== 15'd0) begin
      n_miss++;
      $display("FAIL rstmid_outputs: map=%b score=%0d playing=%b game_over=%b, want all 0", map, score, playing, game_over);
    end
    rst = 1'b1;
    repeat (5) tick();
    n_vec++;
    if ({map, score, playing, game_over} !== 15'd0) begin
      n_miss++;
      $display("FAIL rstmid_idle: map=%b score=%0d playing=%b game_over=%b, want all 0", map, score, playing, game_over);
    end
  endtask

  task automatic test_random_games();
    logic [8:0] last_mole;
    logic [8:0] prev_map;
    logic [3:0] exp_sc;
    logic       done;
    last_mole = '0;
    prev_map  = '0;
    for (int g = 0; g < 100; g++) begin
      exp_sc = 4'd0;
      done   = 1'b0;
      start  = 1'b1;
      hit    = '0;
      exp_q.push_back(4'd0);
      for (int c = 0; c < 300 && !done; c++) begin
        tick();
        start = 1'b0;
        hit   = '0;
        e = exp_q.pop_front();
        n_vec++;
        if (score !== e) begin
          n_miss++;
          $display("FAIL rand_score g%0d c%0d: got %0d want %0d", g, c, score, e);
        end
        n_vec++;
        if (!$onehot0(map)) begin
          n_miss++;
          $display("FAIL rand_onehot g%0d c%0d: map=%b", g, c, map);
        end
        if (map !== 9'd0 && prev_map === 9'd0) begin
          if (last_mole !== 9'd0) begin
            n_vec++;
            if (map === last_mole) begin
              n_miss++;
              $display("FAIL rand_distinct g%0d c%0d: map=%b repeats previous hole", g, c, map);
            end
          end
          last_mole = map;
        end
        prev_map = map;
        if (game_over === 1'b1) begin
          done = 1'b1;
        end else begin
          if ($urandom_range(0, 3) == 0) hit = 9'($urandom_range(1, 511));
          if ((hit & map) != 9'd0) exp_sc = exp_sc + 4'd1;
          exp_q.push_back(exp_sc);
        end
      end
      n_vec++;
      if (!done) begin
        n_miss++;
        $display("FAIL rand_timeout g%0d: game_over=%b, want 1 within 300 cycles", g, game_over);
        exp_q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_hits();
    test_hit_third();
    test_wrong_hole();
    test_back_to_back();
    test_reset_mid();
    test_random_games();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
